cg_rvarch_wb_arbiter: RTL and testbench



---
 rtl/cg_rvarch_pkg.sv | 17 +
 rtl/cg_rr_arbiter.sv | 43 ++++
 rtl/cg_rvarch_wb_arbiter.sv | 77 +++++++
 tb/tb_cg_rvarch_wb_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cg_rvarch_pkg.sv
// Shared register-file constants and types for the RISC-V architectural slice.
package cg_rvarch_pkg;

    localparam int RF_DEPTH = 32;
    localparam int RF_WIDTH = 32;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int REG_AW = addr_width(RF_DEPTH);

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/cg_rr_arbiter.sv
// Round-robin arbiter: search starts at the pointer and wraps upward;
// the pointer moves past the winner whenever the grant is consumed.
module cg_rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_adv,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_gnt_idx
);

    logic [IW-1:0] ptr;
    logic          found;
    int            j;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && i_req[j]) begin
                found     = 1'b1;
                o_gnt[j]  = 1'b1;
                o_gnt_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr <= '0;
        end else if (i_adv) begin
            ptr <= (o_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cg_rvarch_wb_arbiter.sv
// Write-back arbiter for the single register-file write port, plus the
// busy scoreboard that issue logic consults for RAW hazards.
module cg_rvarch_wb_arbiter
    import cg_rvarch_pkg::*;
#(
    parameter int DATA_WIDTH = RF_WIDTH,
    parameter int DATA_NUM   = RF_DEPTH,
    parameter int NUM_REQ    = 3,
    localparam int AW = addr_width(DATA_NUM),
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*AW-1:0]         i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic                          i_alloc_valid,
    input  logic [AW-1:0]                 i_alloc_addr,
    output logic                          o_rd_we,
    output logic [AW-1:0]                 o_rd_addr,
    output logic [DATA_WIDTH-1:0]         o_rd_data,
    output logic [DATA_NUM-1:0]           o_busy
);

    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  hs;
    logic [AW-1:0]         win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  win_nz;
    logic                  alloc_nz;
    logic [DATA_NUM-1:0]   busy_nxt;

    cg_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req_valid),
        .i_adv     (hs),
        .o_gnt     (gnt),
        .o_gnt_idx (gnt_idx)
    );

    assign o_req_ready = i_rst ? '0 : gnt;
    assign hs          = |(o_req_ready & i_req_valid);
    assign win_addr    = i_req_addr[int'(gnt_idx)*AW +: AW];
    assign win_data    = i_req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign win_nz      = (win_addr != AW'(REG_ZERO));
    assign alloc_nz    = (i_alloc_addr != AW'(REG_ZERO));

    // Set is applied after clear so a new producer keeps ownership.
    always_comb begin
        busy_nxt = o_busy;
        if (hs && win_nz) busy_nxt[win_addr] = 1'b0;
        if (i_alloc_valid && alloc_nz) busy_nxt[i_alloc_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rd_we   <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
            o_busy    <= '0;
        end else begin
            o_rd_we <= hs && win_nz;
            if (hs) begin
                o_rd_addr <= win_addr;
                o_rd_data <= win_data;
            end
            o_busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_cg_rvarch_wb_arbiter.sv
// Self-checking bench for cg_rvarch_wb_arbiter against a queue-free
// behavioural model of the grant order, write port and busy bitmap.
module tb_cg_rvarch_wb_arbiter;
    import cg_rvarch_pkg::*;

    localparam int DW = 32;
    localparam int DN = 32;
    localparam int NR = 3;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic            alloc_v;
    logic [AW-1:0]   alloc_a;
    logic            rd_we;
    logic [AW-1:0]   rd_addr;
    logic [DW-1:0]   rd_data;
    logic [DN-1:0]   busy;

    always #5 clk = ~clk;

    cg_rvarch_wb_arbiter #(
        .DATA_WIDTH (DW),
        .DATA_NUM   (DN),
        .NUM_REQ    (NR)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_addr    (req_addr),
        .i_req_data    (req_data),
        .i_alloc_valid (alloc_v),
        .i_alloc_addr  (alloc_a),
        .o_rd_we       (rd_we),
        .o_rd_addr     (rd_addr),
        .o_rd_data     (rd_data),
        .o_busy        (busy)
    );

    int total = 0;
    int bad   = 0;

    bit          va[NR];
    int          aa[NR];
    logic [31:0] da[NR];
    bit          al_v;
    int          al_a;
    bit          rst_v;

    int          m_ptr;
    bit          m_we;
    int          m_addr;
    logic [31:0] m_data;
    logic [31:0] m_busy;
    int          last_g;

    task automatic idle();
        for (int n = 0; n < NR; n++) begin
            va[n] = 1'b0;
            aa[n] = 0;
            da[n] = '0;
        end
        al_v = 1'b0;
        al_a = 0;
    endtask

    task automatic apply();
        for (int n = 0; n < NR; n++) begin
            req_valid[n]          = va[n];
            req_addr[n*AW +: AW]  = AW'(aa[n]);
            req_data[n*DW +: DW]  = da[n];
        end
        alloc_v = al_v;
        alloc_a = AW'(al_a);
        rst     = rst_v;
        #1;
    endtask

    function automatic int exp_grant();
        if (rst_v) return -1;
        for (int i = 0; i < NR; i++) begin
            if (va[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int g);
        logic [NR-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic tick();
        int g;
        g = exp_grant();
        last_g = g;
        @(posedge clk);
        #1;
        if (rst_v) begin
            m_we = 0; m_addr = 0; m_data = '0; m_busy = '0; m_ptr = 0;
        end else begin
            m_we = (g >= 0) && (aa[g] != 0);
            if (g >= 0) begin
                m_addr = aa[g];
                m_data = da[g];
                m_ptr  = (g + 1) % NR;
                if (aa[g] != 0) m_busy[aa[g]] = 1'b0;
            end
            if (al_v && al_a != 0) m_busy[al_a] = 1'b1;
            m_busy[0] = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_v = 1'b1;
        for (int n = 0; n < NR; n++) begin
            va[n] = 1'b1; aa[n] = n + 1; da[n] = $urandom;
        end
        apply();
        total++;
        if (req_ready !== 3'b000) begin
            bad++; $display("FAIL reset_ready got=%b exp=000", req_ready);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (rd_we !== 1'b0 || busy !== 32'h0) begin
                bad++;
                $display("FAIL reset_state we=%b busy=%h exp we=0 busy=0", rd_we, busy);
            end
        end
        rst_v = 1'b0;
        idle();
        apply();
        tick();
        total++;
        if (rd_we !== 1'b0 || busy !== 32'h0 || req_ready !== 3'b000) begin
            bad++;
            $display("FAIL reset_idle we=%b busy=%h rdy=%b exp 0/0/000", rd_we, busy, req_ready);
        end
        total++;
        if (rd_addr !== 5'd0 || rd_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_port addr=%h data=%h exp 0/0", rd_addr, rd_data);
        end
    endtask

    task automatic test_single();
        idle();
        va[1] = 1'b1; aa[1] = 5; da[1] = 32'hDEADBEEF;
        apply();
        total++;
        if (req_ready !== 3'b010) begin
            bad++; $display("FAIL single_ready got=%b exp=010", req_ready);
        end
        tick();
        idle();
        apply();
        total++;
        if (rd_we !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_write we=%b addr=%0d data=%h exp 1/5/deadbeef", rd_we, rd_addr, rd_data);
        end
        tick();
        total++;
        if (rd_we !== 1'b0 || rd_addr !== 5'd5 || rd_data !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_hold we=%b addr=%0d data=%h exp 0/5/deadbeef", rd_we, rd_addr, rd_data);
        end
    endtask

    task automatic test_round_robin();
        rst_v = 1'b1;
        idle();
        apply();
        tick();
        rst_v = 1'b0;
        for (int n = 0; n < NR; n++) begin
            va[n] = 1'b1; aa[n] = 10 + n; da[n] = 32'hA0 + n;
        end
        apply();
        for (int c = 0; c < 6; c++) begin
            total++;
            if (req_ready !== onehot(c % NR) || req_ready !== onehot(exp_grant())) begin
                bad++;
                $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, req_ready, onehot(c % NR));
            end
            tick();
            total++;
            if (rd_we !== 1'b1 || rd_addr !== AW'(10 + c % NR) || rd_data !== 32'hA0 + c % NR) begin
                bad++;
                $display("FAIL rr_write cyc=%0d we=%b addr=%0d exp 1/%0d", c, rd_we, rd_addr, 10 + c % NR);
            end
        end
        idle();
        apply();
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        al_v = 1'b1; al_a = 7;
        apply();
        tick();
        idle();
        apply();
        for (int c = 1; c <= 4; c++) begin
            total++;
            if (busy[7] !== 1'b1) begin
                bad++; $display("FAIL sb_set t+%0d got=%b exp=1", c, busy[7]);
            end
            if (c < 4) tick();
        end
        va[2] = 1'b1; aa[2] = 7; da[2] = 32'h0BAD_F00D;
        apply();
        total++;
        if (req_ready !== 3'b100) begin
            bad++; $display("FAIL sb_ready got=%b exp=100", req_ready);
        end
        tick();
        idle();
        apply();
        total++;
        if (busy[7] !== 1'b0 || rd_we !== 1'b1 || rd_addr !== 5'd7) begin
            bad++;
            $display("FAIL sb_clear busy7=%b we=%b addr=%0d exp 0/1/7", busy[7], rd_we, rd_addr);
        end
    endtask

    task automatic test_collision_x0();
        int seq[3];
        seq = '{2, 0, 1};
        idle();
        al_v = 1'b1; al_a = 9;
        apply();
        tick();
        total++;
        if (busy[9] !== 1'b1) begin
            bad++; $display("FAIL col_set got=%b exp=1", busy[9]);
        end
        idle();
        va[0] = 1'b1; aa[0] = 9; da[0] = 32'h1234;
        al_v = 1'b1; al_a = 9;
        apply();
        tick();
        idle();
        apply();
        total++;
        if (busy[9] !== 1'b1 || rd_we !== 1'b1 || rd_addr !== 5'd9) begin
            bad++;
            $display("FAIL col_setwins busy9=%b we=%b addr=%0d exp 1/1/9", busy[9], rd_we, rd_addr);
        end
        va[1] = 1'b1; aa[1] = 0; da[1] = 32'h5555;
        apply();
        total++;
        if (req_ready !== 3'b010) begin
            bad++; $display("FAIL x0_ready got=%b exp=010", req_ready);
        end
        tick();
        idle();
        apply();
        total++;
        if (rd_we !== 1'b0 || busy !== m_busy) begin
            bad++;
            $display("FAIL x0_write we=%b busy=%h exp 0/%h", rd_we, busy, m_busy);
        end
        for (int n = 0; n < NR; n++) begin
            va[n] = 1'b1; aa[n] = 20 + n; da[n] = 32'hC0 + n;
        end
        apply();
        for (int c = 0; c < 3; c++) begin
            total++;
            if (req_ready !== onehot(seq[c])) begin
                bad++;
                $display("FAIL x0_ptr cyc=%0d got=%b exp=%b", c, req_ready, onehot(seq[c]));
            end
            tick();
            if (last_g >= 0) va[last_g] = 1'b0;
            apply();
        end
        idle();
        al_v = 1'b1; al_a = 0;
        apply();
        tick();
        total++;
        if (busy !== m_busy || busy[0] !== 1'b0) begin
            bad++; $display("FAIL x0_alloc busy=%h exp=%h", busy, m_busy);
        end
    endtask

    task automatic test_random();
        int wt[NR];
        for (int n = 0; n < NR; n++) wt[n] = 0;
        idle();
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < NR; n++) begin
                if (!va[n] && ($urandom % 2 == 0)) begin
                    va[n] = 1'b1;
                    aa[n] = $urandom % DN;
                    da[n] = $urandom;
                    wt[n] = 0;
                end
            end
            al_a = $urandom % DN;
            al_v = ($urandom % 3 == 0) && !(al_a != 0 && m_busy[al_a]);
            apply();
            total++;
            if (req_ready !== onehot(exp_grant())) begin
                bad++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, req_ready, onehot(exp_grant()));
            end
            tick();
            total++;
            if (rd_we !== m_we || busy !== m_busy) begin
                bad++;
                $display("FAIL rnd_state cyc=%0d we=%b busy=%h exp %b/%h", c, rd_we, busy, m_we, m_busy);
            end
            if (m_we) begin
                total++;
                if (rd_addr !== AW'(m_addr) || rd_data !== m_data) begin
                    bad++;
                    $display("FAIL rnd_data cyc=%0d addr=%0d data=%h exp %0d/%h", c, rd_addr, rd_data, m_addr, m_data);
                end
            end
            if (last_g >= 0) begin
                total++;
                if (wt[last_g] >= NR) begin
                    bad++;
                    $display("FAIL rnd_fair req=%0d waited=%0d limit=%0d", last_g, wt[last_g], NR - 1);
                end
                va[last_g] = 1'b0;
            end
            for (int n = 0; n < NR; n++) if (va[n]) wt[n]++;
        end
        while (va[0] || va[1] || va[2]) begin
            al_v = 1'b0;
            apply();
            tick();
            if (last_g >= 0) va[last_g] = 1'b0;
        end
        idle();
        apply();
        tick();
    endtask

    task automatic test_reset_mid();
        rst_v = 1'b1;
        idle();
        apply();
        tick();
        rst_v = 1'b0;
        for (int r = 4; r < 8; r++) begin
            al_v = 1'b1; al_a = r;
            apply();
            tick();
        end
        idle();
        apply();
        total++;
        if (busy !== 32'h0000_00F0) begin
            bad++; $display("FAIL mid_busy got=%h exp=000000f0", busy);
        end
        rst_v = 1'b1;
        va[1] = 1'b1; aa[1] = 3; da[1] = 32'h7777;
        apply();
        total++;
        if (req_ready !== 3'b000) begin
            bad++; $display("FAIL mid_ready got=%b exp=000", req_ready);
        end
        tick();
        rst_v = 1'b0;
        for (int n = 0; n < NR; n++) begin
            va[n] = 1'b1; aa[n] = 12 + n; da[n] = 32'hE0 + n;
        end
        apply();
        total++;
        if (rd_we !== 1'b0 || busy !== 32'h0) begin
            bad++; $display("FAIL mid_clear we=%b busy=%h exp 0/0", rd_we, busy);
        end
        total++;
        if (req_ready !== 3'b001) begin
            bad++; $display("FAIL mid_restart got=%b exp=001", req_ready);
        end
        for (int c = 0; c < NR; c++) begin
            tick();
            if (last_g >= 0) va[last_g] = 1'b0;
            apply();
        end
        idle();
        apply();
        tick();
    endtask

    initial begin
        m_ptr = 0; m_we = 0; m_addr = 0; m_data = '0; m_busy = '0; last_g = -1;
        rst_v = 1'b1;
        idle();
        apply();
        test_reset();
        test_single();
        test_round_robin();
        test_scoreboard();
        test_collision_x0();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
